// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage generator.
// Walks Stage through 1..NUM_STAGES for each instruction, under control of
// free-run, single-step, stall and halt requests, and keeps debug counters
// of completed instructions and active (Stage != 0) cycles.
module stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int COUNT_W    = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Step,
  input  logic               Stall,
  input  logic               Halt_Req,
  input  logic               Clear_Halt,
  input  logic               Count_Clear,
  output logic [2:0]         Stage,
  output logic               Instr_Done,
  output logic               Busy,
  output logic               Halted,
  output logic [COUNT_W-1:0] Instr_Count,
  output logic [COUNT_W-1:0] Cycle_Count
);

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_RUNNING,
    MODE_STEPPING,
    MODE_HALTED
  } mode_t;

  localparam logic [2:0]         LAST_STAGE = 3'(NUM_STAGES);
  localparam logic [2:0]         FIRST_STAGE = 3'd1;
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  mode_t mode;
  logic  halt_pending;
  logic  active;
  logic  completing;

  // An instruction completes on the edge that leaves its last stage unstalled.
  always_comb begin
    active     = (mode == MODE_RUNNING) || (mode == MODE_STEPPING);
    completing = active && !Stall && (Stage == LAST_STAGE);
  end

  // Mode FSM, stage walker, registered status flags and debug counters.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mode         <= MODE_IDLE;
      Stage        <= 3'd0;
      halt_pending <= 1'b0;
      Instr_Done   <= 1'b0;
      Busy         <= 1'b0;
      Halted       <= 1'b0;
      Instr_Count  <= '0;
      Cycle_Count  <= '0;
    end else begin
      Instr_Done <= completing;

      if (Count_Clear) begin
        Instr_Count <= '0;
        Cycle_Count <= '0;
      end else begin
        if (completing)
          Instr_Count <= Instr_Count + CNT_ONE;
        if (Stage != 3'd0)
          Cycle_Count <= Cycle_Count + CNT_ONE;
      end

      case (mode)
        MODE_IDLE: begin
          if (Halt_Req) begin
            mode         <= MODE_HALTED;
            Halted       <= 1'b1;
            Busy         <= 1'b0;
            halt_pending <= 1'b0;
            Stage        <= 3'd0;
          end else if (Run) begin
            mode  <= MODE_RUNNING;
            Busy  <= 1'b1;
            Stage <= FIRST_STAGE;
          end else if (Step) begin
            mode  <= MODE_STEPPING;
            Busy  <= 1'b1;
            Stage <= FIRST_STAGE;
          end
        end

        MODE_RUNNING, MODE_STEPPING: begin
          if (Halt_Req)
            halt_pending <= 1'b1;
          if (!Stall) begin
            if (Stage != LAST_STAGE) begin
              Stage <= Stage + 3'd1;
            end else if (halt_pending || Halt_Req) begin
              mode         <= MODE_HALTED;
              Halted       <= 1'b1;
              Busy         <= 1'b0;
              halt_pending <= 1'b0;
              Stage        <= 3'd0;
            end else if ((mode == MODE_STEPPING) || !Run) begin
              mode  <= MODE_IDLE;
              Busy  <= 1'b0;
              Stage <= 3'd0;
            end else begin
              Stage <= FIRST_STAGE;
            end
          end
        end

        MODE_HALTED: begin
          Stage <= 3'd0;
          if (Clear_Halt) begin
            mode   <= MODE_IDLE;
            Halted <= 1'b0;
          end
        end

        default: begin
          mode   <= MODE_IDLE;
          Stage  <= 3'd0;
          Busy   <= 1'b0;
          Halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
